// File: rtl/iommu_pkg.sv
// Shared IOMMU interrupt-generation types and constants.
// Coalescer state encoding, ipsr bit positions and the wired-vector count.
package iommu_pkg;

   typedef enum logic [1:0] {
      C_IDLE  = 2'd0,
      C_ACCUM = 2'd1,
      C_FIRE  = 2'd2
   } coal_state_e;

   localparam int unsigned IPSR_CIP   = 0;
   localparam int unsigned IPSR_FIP   = 1;
   localparam int unsigned N_INT_VEC  = 16;
   localparam int unsigned COAL_CNT_W = 8;
   localparam int unsigned COAL_TMR_W = 16;

endpackage

// File: rtl/iommu_ip_coalescer.sv
// Fault-record interrupt coalescer: counts FQ records and emits a one-cycle
// fire pulse on threshold, timeout or FQ error. Built only with IOMMU_IP_COALESCE_EN.
module iommu_ip_coalescer
   import iommu_pkg::*;
#(
   parameter int unsigned COAL_THRESH  = 4,
   parameter int unsigned COAL_TIMEOUT = 256
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic fie_i,
   input  logic fq_rec_i,
   input  logic fq_err_i,
   output logic fire_o
);

   localparam logic [COAL_CNT_W-1:0] THRESH    = COAL_CNT_W'(COAL_THRESH);
   localparam logic [COAL_TMR_W-1:0] TMO_LAST  = COAL_TMR_W'(COAL_TIMEOUT - 1);
   // A batch that would fire on its first record skips the accumulate state.
   localparam logic                  IMMEDIATE = (COAL_THRESH <= 1) || (COAL_TIMEOUT <= 1);

   coal_state_e               state_reg, state_next;
   logic [COAL_CNT_W-1:0]     count_reg, count_next, count_acc;
   logic [COAL_TMR_W-1:0]     timer_reg, timer_next, timer_acc;

   assign count_acc = (fq_rec_i && (count_reg < THRESH)) ? count_reg + 1'b1 : count_reg;
   assign timer_acc = (timer_reg == {COAL_TMR_W{1'b1}}) ? timer_reg : timer_reg + 1'b1;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= C_IDLE;
         count_reg <= '0;
         timer_reg <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         timer_reg <= timer_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      timer_next = timer_reg;
      if (!fie_i) begin
         state_next = C_IDLE;
         count_next = '0;
         timer_next = '0;
      end else begin
         case (state_reg)
            C_IDLE: begin
               if (fq_rec_i) begin
                  count_next = COAL_CNT_W'(1);
                  timer_next = '0;
                  state_next = IMMEDIATE ? C_FIRE : C_ACCUM;
               end
            end
            C_ACCUM: begin
               count_next = count_acc;
               timer_next = timer_acc;
               if ((count_acc >= THRESH) || (timer_acc >= TMO_LAST) || fq_err_i) begin
                  state_next = C_FIRE;
               end
            end
            C_FIRE: begin
               count_next = '0;
               timer_next = '0;
               state_next = C_IDLE;
               // A record landing on the fire cycle opens the next batch.
               if (fq_rec_i) begin
                  count_next = COAL_CNT_W'(1);
                  state_next = C_ACCUM;
               end
            end
            default: state_next = C_IDLE;
         endcase
      end
   end

   always_comb begin
      fire_o = (state_reg == C_FIRE);
   end

endmodule

// File: rtl/iommu_ip_gen.sv
// IOMMU interrupt-pending generation: cip/fip with W1C, enables and wired lines.
// Define IOMMU_IP_COALESCE_EN to coalesce fault-record interrupts.
module iommu_ip_gen
   import iommu_pkg::*;
#(
   parameter int unsigned COAL_THRESH  = 4,
   parameter int unsigned COAL_TIMEOUT = 256
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cie_i,
   input  logic                 fie_i,
   input  logic                 cq_evt_i,
   input  logic                 fq_rec_i,
   input  logic                 fq_err_i,
   input  logic                 ipsr_we_i,
   input  logic [1:0]           ipsr_wdata_i,
   input  logic                 wsi_en_i,
   input  logic [3:0]           civ_i,
   input  logic [3:0]           fiv_i,
   output logic                 cip_o,
   output logic                 fip_o,
   output logic [N_INT_VEC-1:0] wsi_o
);

   logic                 cip_reg, cip_next;
   logic                 fip_reg, fip_next;
   logic                 fip_set;
   logic [N_INT_VEC-1:0] wsi_reg, wsi_next;

`ifdef IOMMU_IP_COALESCE_EN
   logic coal_fire;

   iommu_ip_coalescer #(
      .COAL_THRESH  (COAL_THRESH),
      .COAL_TIMEOUT (COAL_TIMEOUT)
   ) u_coalescer (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .fie_i    (fie_i),
      .fq_rec_i (fq_rec_i),
      .fq_err_i (fq_err_i),
      .fire_o   (coal_fire)
   );

   assign fip_set = fie_i && (fq_err_i || coal_fire);
`else
   // Without coalescing the parameters only gate out a nonsensical zero configuration.
   localparam logic COAL_CFG_OK = (COAL_THRESH >= 1) && (COAL_TIMEOUT >= 1);

   assign fip_set = fie_i && (fq_rec_i || fq_err_i) && COAL_CFG_OK;
`endif

   // Set has priority over W1C so an event coinciding with a clear is never lost.
   always_comb begin
      cip_next = cip_reg;
      fip_next = fip_reg;
      if (ipsr_we_i && ipsr_wdata_i[IPSR_CIP]) cip_next = 1'b0;
      if (ipsr_we_i && ipsr_wdata_i[IPSR_FIP]) fip_next = 1'b0;
      if (cq_evt_i && cie_i)                   cip_next = 1'b1;
      if (fip_set)                             fip_next = 1'b1;
   end

   for (genvar gi = 0; gi < N_INT_VEC; gi++) begin : g_wsi
      assign wsi_next[gi] = wsi_en_i && ((cip_reg && (civ_i == 4'(gi))) ||
                                         (fip_reg && (fiv_i == 4'(gi))));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cip_reg <= 1'b0;
         fip_reg <= 1'b0;
         wsi_reg <= '0;
      end else begin
         cip_reg <= cip_next;
         fip_reg <= fip_next;
         wsi_reg <= wsi_next;
      end
   end

   assign cip_o = cip_reg;
   assign fip_o = fip_reg;
   assign wsi_o = wsi_reg;

endmodule

// File: tb/tb_iommu_ip_gen.sv
// Self-checking bench for iommu_ip_gen: event-time reference model plus directed cases.
// Honours IOMMU_IP_COALESCE_EN in the same way as the design.
`timescale 1ns/1ps
module tb_iommu_ip_gen;

   localparam int THRESH = 4;
   localparam int TMO    = 256;

   logic        clk = 1'b0;
   logic        rst, cie, fie, cq_evt, fq_rec, fq_err, ipsr_we, wsi_en;
   logic [1:0]  ipsr_wdata;
   logic [3:0]  civ, fiv;
   logic        cip, fip;
   logic [15:0] wsi;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   iommu_ip_gen #(
      .COAL_THRESH  (THRESH),
      .COAL_TIMEOUT (TMO)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .cie_i        (cie),
      .fie_i        (fie),
      .cq_evt_i     (cq_evt),
      .fq_rec_i     (fq_rec),
      .fq_err_i     (fq_err),
      .ipsr_we_i    (ipsr_we),
      .ipsr_wdata_i (ipsr_wdata),
      .wsi_en_i     (wsi_en),
      .civ_i        (civ),
      .fiv_i        (fiv),
      .cip_o        (cip),
      .fip_o        (fip),
      .wsi_o        (wsi)
   );

   // Reference model: pending bits plus a batch described by its scheduled fire cycle.
   bit        m_cip = 1'b0, m_fip = 1'b0;
   bit [15:0] m_wsi = '0;
   int        cyc = 0;
   bit        b_act = 1'b0;
   int        b_n = 0;
   int        b_fire_at = -1;
   bit        chk_en = 1'b0;

   always @(posedge clk) begin : model
      bit        set_c, set_f, fire_now, nb;
      int        nn, nfa;
      bit [15:0] w;
      fire_now = (b_fire_at == cyc);
`ifdef IOMMU_IP_COALESCE_EN
      set_f = fie && (fq_err || fire_now);
`else
      set_f = fie && (fq_rec || fq_err);
`endif
      set_c = cie && cq_evt;
      w = '0;
      if (wsi_en) begin
         if (m_cip) w[civ] = 1'b1;
         if (m_fip) w[fiv] = 1'b1;
      end
      nb = b_act; nn = b_n; nfa = b_fire_at;
      if (rst || !fie) begin
         nb = 1'b0; nn = 0; nfa = -1;
      end else begin
         if (fire_now) begin
            nb = 1'b0; nfa = -1;
         end
         if (nb) begin
            if (fq_rec && nn < THRESH) nn++;
            if ((nn >= THRESH || fq_err) && (cyc + 1 < nfa)) nfa = cyc + 1;
         end else if (fq_rec) begin
            nb = 1'b1; nn = 1;
            nfa = (THRESH <= 1) ? cyc + 1 : cyc + TMO;
         end
      end
      if (rst) begin
         m_cip <= 1'b0; m_fip <= 1'b0; m_wsi <= '0;
      end else begin
         m_cip <= set_c ? 1'b1 : (ipsr_we && ipsr_wdata[0]) ? 1'b0 : m_cip;
         m_fip <= set_f ? 1'b1 : (ipsr_we && ipsr_wdata[1]) ? 1'b0 : m_fip;
         m_wsi <= w;
      end
      b_act     <= nb;
      b_n       <= nn;
      b_fire_at <= nfa;
      cyc       <= cyc + 1;
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("cip", {15'd0, cip}, {15'd0, m_cip});
         check("fip", {15'd0, fip}, {15'd0, m_fip});
         check("wsi", wsi, m_wsi);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic w1c(input logic [1:0] d);
      ipsr_we = 1'b1; ipsr_wdata = d;
      step(1);
      ipsr_we = 1'b0; ipsr_wdata = 2'b00;
   endtask

   initial begin
      rst = 1'b1; cie = 1'b0; fie = 1'b0; cq_evt = 1'b0; fq_rec = 1'b0; fq_err = 1'b0;
      ipsr_we = 1'b0; ipsr_wdata = 2'b00; wsi_en = 1'b0; civ = 4'd0; fiv = 4'd0;
      step(3);
      rst = 1'b0;
      chk_en = 1'b1;
      check("rst_cip", {15'd0, cip}, 16'd0);
      check("rst_fip", {15'd0, fip}, 16'd0);
      check("rst_wsi", wsi, 16'd0);

      // CQ event sets cip one cycle later; W1C clears it one cycle later.
      cie = 1'b1;
      step(7);
      cq_evt = 1'b1; step(1); cq_evt = 1'b0;
      $display("txn cq_evt cie=1 -> cip=%0b", cip);
      check("cip_set", {15'd0, cip}, 16'd1);
      step(8);
      w1c(2'b01);
      $display("txn w1c 01 -> cip=%0b", cip);
      check("cip_w1c", {15'd0, cip}, 16'd0);

      // Disabled events are dropped and not remembered.
      cie = 1'b0;
      cq_evt = 1'b1; step(1); cq_evt = 1'b0;
      check("cip_disabled", {15'd0, cip}, 16'd0);
      cie = 1'b1; step(3);
      $display("txn cq_evt cie=0 then cie=1 -> cip=%0b", cip);
      check("cip_not_remembered", {15'd0, cip}, 16'd0);

      // Set wins over a same-cycle W1C.
      cq_evt = 1'b1; step(1); cq_evt = 1'b0;
      cq_evt = 1'b1; ipsr_we = 1'b1; ipsr_wdata = 2'b01;
      step(1);
      cq_evt = 1'b0; ipsr_we = 1'b0; ipsr_wdata = 2'b00;
      $display("txn cq_evt + w1c same cycle -> cip=%0b", cip);
      check("cip_set_wins", {15'd0, cip}, 16'd1);
      cie = 1'b0;
      check("cip_enable_drop_keeps", {15'd0, cip}, 16'd1);
      w1c(2'b01);
      cie = 1'b1;

      // FQ path: error always signals directly; records too when not coalescing.
      fie = 1'b1;
      fq_err = 1'b1; step(1); fq_err = 1'b0;
      $display("txn fq_err fie=1 -> fip=%0b", fip);
      check("fip_err", {15'd0, fip}, 16'd1);
      w1c(2'b10);
      check("fip_w1c", {15'd0, fip}, 16'd0);
`ifndef IOMMU_IP_COALESCE_EN
      fq_rec = 1'b1; step(1); fq_rec = 1'b0;
      check("fip_rec", {15'd0, fip}, 16'd1);
      w1c(2'b10);
      fie = 1'b0; fq_rec = 1'b1; step(1); fq_rec = 1'b0;
      check("fip_rec_disabled", {15'd0, fip}, 16'd0);
      fie = 1'b1;
`endif

      // Wired lines: shared vector ORs both pending bits onto one line.
      wsi_en = 1'b1; civ = 4'd3; fiv = 4'd3;
      cq_evt = 1'b1; fq_err = 1'b1; step(1); cq_evt = 1'b0; fq_err = 1'b0;
      step(1);
      $display("txn wsi civ=fiv=3 both pending -> wsi=%h", wsi);
      check("wsi_shared", wsi, 16'h0008);
      w1c(2'b01); step(1);
      check("wsi_shared_cip_clr", wsi, 16'h0008);
      check("cip_clr_wsi", {15'd0, cip}, 16'd0);
      w1c(2'b10); step(1);
      check("wsi_shared_all_clr", wsi, 16'h0000);
      civ = 4'd2; fiv = 4'd9;
      cq_evt = 1'b1; fq_err = 1'b1; step(1); cq_evt = 1'b0; fq_err = 1'b0;
      step(1);
      check("wsi_split", wsi, 16'h0204);
      wsi_en = 1'b0; step(1);
      check("wsi_disabled", wsi, 16'h0000);
      w1c(2'b11);

`ifdef IOMMU_IP_COALESCE_EN
      rst = 1'b1; step(1); rst = 1'b0;
      // Threshold: records at relative cycles 0,2,4,6 -> fip visible at 8.
      for (int c = 0; c < 8; c++) begin
         fq_rec = ((c % 2) == 0) && (c <= 6);
         step(1);
         if (c == 6) check("coal_early", {15'd0, fip}, 16'd0);
         if (c == 7) check("coal_thresh", {15'd0, fip}, 16'd1);
      end
      fq_rec = 1'b0;
      $display("txn 4 records -> fip=%0b", fip);
      w1c(2'b10);
      // Timeout: a lone record at 0 -> fip visible at TMO+1.
      for (int c = 0; c <= TMO; c++) begin
         fq_rec = (c == 0);
         step(1);
         if (c == TMO - 1) check("coal_tmo_early", {15'd0, fip}, 16'd0);
         if (c == TMO)     check("coal_tmo", {15'd0, fip}, 16'd1);
      end
      fq_rec = 1'b0;
      $display("txn lone record timeout -> fip=%0b", fip);
      w1c(2'b10);
      // Dropping fie mid-batch discards it.
      for (int c = 0; c <= 300; c++) begin
         fq_rec = (c == 0);
         fie = (c < 100);
         step(1);
         if (c == TMO) check("coal_fie_drop", {15'd0, fip}, 16'd0);
      end
      fq_rec = 1'b0; fie = 1'b1;
      $display("txn fie dropped mid-batch -> fip=%0b", fip);
`endif

      // Randomized traffic: dense records first, then sparse ones to reach timeouts.
      for (int i = 0; i < 3000; i++) begin
         rst    = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 15) == 0) cie = ~cie;
         if ($urandom_range(0, 31) == 0) fie = ~fie;
         if ($urandom_range(0, 19) == 0) wsi_en = ~wsi_en;
         if ($urandom_range(0, 9) == 0) begin
            civ = 4'($urandom_range(0, 15));
            fiv = 4'($urandom_range(0, 15));
         end
         cq_evt     = ($urandom_range(0, 7) == 0);
         fq_rec     = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
         fq_err     = ($urandom_range(0, 63) == 0);
         ipsr_we    = ($urandom_range(0, 5) == 0);
         ipsr_wdata = 2'($urandom_range(0, 3));
         step(1);
      end
      rst = 1'b0; cq_evt = 1'b0; fq_rec = 1'b0; fq_err = 1'b0; ipsr_we = 1'b0;
      step(2);
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iommu_ip_gen.md
# iommu_ip_gen

Interrupt-pending generation stage of the IOMMU. It turns command-queue and fault-queue event pulses into the level `cip`/`fip` pending bits consumed by the MSI interrupt generator. It owns the ipsr W1C semantics and the per-queue interrupt enables, and optionally coalesces fault-record interrupts. In wired-signalled mode it also drives the 16 wired interrupt lines selected by `civ`/`fiv`.

## Interface
Parameters:
- `COAL_THRESH`, default 4: fault records per coalesced interrupt (1..255).
- `COAL_TIMEOUT`, default 256: cycles from first unsignalled record to forced interrupt (1..65535).

Ports:
- `clk_i` in 1: clock. Single clock domain.
- `rst_i` in 1: reset. Synchronous, active-high.
- `cie_i` in 1: CQ interrupt enable (cqcsr.cie).
- `fie_i` in 1: FQ interrupt enable (fqcsr.fie).
- `cq_evt_i` in 1: one-cycle pulse for a CQ interrupt event (error, timeout, fence with `wsi`).
- `fq_rec_i` in 1: one-cycle pulse when a fault record is written to the FQ.
- `fq_err_i` in 1: one-cycle pulse when the FQ overflows or has a memory fault.
- `ipsr_we_i` in 1: ipsr software write strobe.
- `ipsr_wdata_i` in 2: bit0 = cip, bit1 = fip. Write-1-to-clear.
- `wsi_en_i` in 1: 1 selects wired signalling, 0 selects MSI.
- `civ_i`, `fiv_i` in 4: interrupt vector indices.
- `cip_o`, `fip_o` out 1: pending bits, fed to the MSI generator and to ipsr readback.
- `wsi_o` out 16: wired interrupt lines, level-sensitive.

## Operation
- Set rule: a pending bit sets only when its enable is 1 on the event cycle. Events arriving with enable 0 are dropped and are not remembered.
- `cip` sets on `cq_evt_i && cie_i`.
- `fip` sets on `fq_err_i && fie_i`, or on a coalescer fire while `fie_i`.
- Clear rule: `ipsr_we_i` with a data bit of 1 clears that pending bit. A data bit of 0 has no effect.
- Same-cycle set and W1C: set wins, so the bit stays 1. This guarantees no event is lost; the MSI stage sees a fresh edge after software's next clear.
- Enable deassert: it does not clear an already-set pending bit.
- `wsi_o`:
  - When `wsi_en_i` = 1: `wsi_o[civ_i] |= cip`, `wsi_o[fiv_i] |= fip`. If `civ_i == fiv_i`, the two are OR-ed onto one line.
  - When `wsi_en_i` = 0: `wsi_o` = 0.
  - The pending bits behave identically in both modes.
- Coalescer FSM (FQ records only):
  - `C_IDLE`: on `fq_rec_i`, load count = 1 and timer = 0, then go to `C_ACCUM`. If `COAL_THRESH == 1`, go straight to `C_FIRE` instead.
  - `C_ACCUM`:
    - The timer increments every cycle. Count increments on `fq_rec_i`, saturating at `COAL_THRESH`.
    - Go to `C_FIRE` when count reaches `COAL_THRESH` or timer reaches `COAL_TIMEOUT-1`.
    - `fq_err_i` also forces `C_FIRE`, because the error path already signals.
  - `C_FIRE`: assert the internal fire for one cycle, clear count and timer, go to `C_IDLE`. A `fq_rec_i` arriving in `C_FIRE` is counted into the next batch: go to `C_ACCUM` with count = 1.
  - `fie_i` = 0 in any state: go to `C_IDLE` and clear count and timer.
- Widths: count is 8 bits, timer is 16 bits, both saturating. `wsi_o` OR-reduction is bitwise.

## Timing
- Reset values:
  - `cip_o` = 0, `fip_o` = 0, `wsi_o` = 0.
  - FSM in `C_IDLE`, count = 0, timer = 0.
- Reset mid-batch discards accumulated records.
- Latency:
  - Event pulse in cycle N gives a pending bit of 1 in cycle N+1 (registered).
  - W1C in cycle N gives 0 in cycle N+1.
  - `wsi_o` is registered from the pending bits: one further cycle, i.e. N+2 after the event.
- Coalesced `fip`: the record pulse that reaches threshold in cycle N gives `C_FIRE` in N+1 and `fip_o` = 1 in N+2.
- Timeout: the first record in cycle N gives `fip_o` = 1 in cycle N + `COAL_TIMEOUT` + 1.
- No handshakes. All inputs are sampled every cycle.

## Configuration
- Macro `IOMMU_IP_COALESCE_EN`.
- Defined: the coalescer is built as described above.
- Undefined:
  - No coalescer FSM, counters or timer.
  - `fip` sets on `(fq_rec_i || fq_err_i) && fie_i` with the same one-cycle latency as `cip`.
  - The parameters are ignored.

## Structure
- Shared package `iommu_pkg`:
  - coalescer state enum `coal_state_e` (`C_IDLE`, `C_ACCUM`, `C_FIRE`);
  - ipsr bit-index constants `IPSR_CIP = 0` and `IPSR_FIP = 1`;
  - constant `N_INT_VEC = 16`.
- One sub-module, `iommu_ip_coalescer`: the FSM with count and timer, whose output is a fire pulse. It is instantiated only under the macro.

## Test plan
- `cie_i` = 1, pulse `cq_evt_i` at cycle 10 -> `cip_o` = 1 at cycle 11. Then `ipsr_we_i` with data 2'b01 at cycle 20 -> `cip_o` = 0 at cycle 21.
- `cie_i` = 0, pulse `cq_evt_i` -> `cip_o` stays 0. Set `cie_i` = 1 afterwards -> still 0, because the event is not remembered.
- Same-cycle `cq_evt_i` and W1C of cip, with `cip_o` already 1 -> `cip_o` stays 1.
- With the macro, `COAL_THRESH` = 4: four `fq_rec_i` pulses in cycles 5, 7, 9, 11 -> `fip_o` = 1 at cycle 13, not earlier.
- With the macro, `COAL_TIMEOUT` = 256: a single `fq_rec_i` at cycle 0 -> `fip_o` = 1 at cycle 257. Repeat with `fie_i` dropped at cycle 100 -> `fip_o` stays 0.
- `wsi_en_i` = 1, `civ_i` = `fiv_i` = 3, both pending -> `wsi_o` = 16'h0008. W1C cip only -> `wsi_o` stays 16'h0008. W1C fip -> `wsi_o` = 0.
